nios2_cpu_jtag_debug_scan_master: RTL and testbench

// - Host-side initiator for the 2-bit-IR virtual JTAG debug channel. Turns one
//   {IR, DR} command into a complete scan sequence (UIR, CDR, SDR, UDR) toward the

---
 rtl/nios2_cpu_jtag_debug_scan_master.sv | 197 +++++++++++++++++++
 tb/tb_nios2_cpu_jtag_debug_scan_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_cpu_jtag_debug_scan_master.sv
// Host-side scan master for the 2-bit-IR virtual JTAG debug channel: one {IR, DR}
// command becomes UIR, CDR, SDR, UDR on vji_*. Optional macro JTAG_SCAN_IR_CAPTURE_EN.
module nios2_cpu_jtag_debug_scan_master #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);
    // state | meaning
    // IDLE  | waiting for a command, tck parked low
    // UIR   | one tck period presenting the new IR
    // CDR   | one tck period of capture-DR
    // SDR   | DR_WIDTH tck periods of shifting
    // UDR   | one tck period of update-DR
    // RSP   | captured word offered until rsp_ready
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = $clog2(DR_WIDTH + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RSP} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bits_q, bits_d;
    logic [DR_WIDTH-1:0] shreg_q, shreg_d, rsp_dr_q, rsp_dr_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic tck_q, tck_d, tdi_q, tdi_d;
    logic rti_q, rti_d, uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d;
    logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic active, tick, tck_rise, tck_fall;

    assign active   = (state_q != ST_IDLE) && (state_q != ST_RSP);
    assign tick     = (div_q == DIV_W'(TCK_DIV - 1));
    assign tck_rise = active && tick && !tck_q;
    assign tck_fall = active && tick && tck_q;

    always_comb begin
        state_d     = state_q;
        bits_d      = bits_q;
        shreg_d     = shreg_q;
        rsp_dr_d    = rsp_dr_q;
        ir_in_d     = ir_in_q;
        tdi_d       = tdi_q;
        rti_d       = rti_q;
        uir_d       = uir_q;
        cdr_d       = cdr_q;
        sdr_d       = sdr_q;
        udr_d       = udr_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        if (active) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            tck_d = tick ? ~tck_q : tck_q;
        end else begin
            div_d = '0;
            tck_d = 1'b0;
        end
        // phase boundaries all fall on tck falling edges
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                ir_in_d     = cmd_ir;
                shreg_d     = cmd_dr;
                cmd_ready_d = 1'b0;
                rti_d       = 1'b0;
                uir_d       = 1'b1;
                state_d     = ST_UIR;
            end
            ST_UIR: if (tck_fall) begin
                uir_d   = 1'b0;
                cdr_d   = 1'b1;
                state_d = ST_CDR;
            end
            ST_CDR: if (tck_fall) begin
                cdr_d   = 1'b0;
                sdr_d   = 1'b1;
                tdi_d   = shreg_q[0];
                bits_d  = BIT_W'(DR_WIDTH);
                state_d = ST_SDR;
            end
            ST_SDR: begin
                if (tck_rise) begin
                    shreg_d = {vji_tdo, shreg_q[DR_WIDTH-1:1]};
                    bits_d  = bits_q - BIT_W'(1);
                end
                if (tck_fall) begin
                    if (bits_q == '0) begin
                        sdr_d   = 1'b0;
                        udr_d   = 1'b1;
                        state_d = ST_UDR;
                    end else begin
                        tdi_d = shreg_q[0];
                    end
                end
            end
            ST_UDR: if (tck_fall) begin
                udr_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_dr_d    = shreg_q;
                state_d     = ST_RSP;
            end
            ST_RSP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                rti_d       = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bits_q      <= '0;
            shreg_q     <= '0;
            rsp_dr_q    <= '0;
            ir_in_q     <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            rti_q       <= 1'b1;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bits_q      <= bits_d;
            shreg_q     <= shreg_d;
            rsp_dr_q    <= rsp_dr_d;
            ir_in_q     <= ir_in_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            rti_q       <= rti_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef JTAG_SCAN_IR_CAPTURE_EN
    logic [IR_WIDTH-1:0] ir_cap_q, ir_cap_d;

    always_comb begin
        ir_cap_d = ir_cap_q;
        if ((state_q == ST_CDR) && tck_rise) ir_cap_d = vji_ir_out;
    end

    always_ff @(posedge clk) begin
        if (reset) ir_cap_q <= '0;
        else       ir_cap_q <= ir_cap_d;
    end

    assign rsp_ir_out = ir_cap_q;
`else
    logic unused_ir_out;
    assign unused_ir_out = ^vji_ir_out;
    assign rsp_ir_out    = '0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dr    = rsp_dr_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign vji_rti   = rti_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;
endmodule

// File: tb/tb_nios2_cpu_jtag_debug_scan_master.sv
// Self-checking bench for nios2_cpu_jtag_debug_scan_master: randomized commands and
// target TDO streams checked against a timing/data model derived from scan rules.
module tb_nios2_cpu_jtag_debug_scan_master;
    localparam int IR_W = 2;
    localparam int DR_W = 38;
    localparam int DIV  = 2;
    localparam int PER  = 2 * DIV;
    // edges from the accept edge until rsp_valid is visible
    localparam int LAT  = (DR_W + 3) * PER;

    logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [IR_W-1:0] cmd_ir = '0, vji_ir_out = '0;
    logic [DR_W-1:0] cmd_dr = '0;
    logic cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
    logic vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out, vji_ir_in;

    int checks = 0, errors = 0, cyc = 0, accept_cyc = 0, tck_rises = 0, rise_idx = 0;
    logic tdo_reg = 1'b0, loop_mode = 1'b1, first_bit = 1'b0;
    logic [DR_W-1:0] rnd_word = '0;
    logic tdi_seen[$];

    nios2_cpu_jtag_debug_scan_master #(.IR_WIDTH(IR_W), .DR_WIDTH(DR_W), .TCK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
        .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
        .vji_udr(vji_udr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Target model: loopback returns tdi delayed by one tck (first_bit before the
    // first shift), otherwise streams rnd_word LSB first.
    assign vji_tdo = tdo_reg;
    always @(posedge vji_tck) begin
        tck_rises++;
        if (vji_uir) begin
            rise_idx = 0;
            tdi_seen.delete();
            tdo_reg = loop_mode ? first_bit : rnd_word[0];
        end else if (vji_sdr) begin
            tdi_seen.push_back(vji_tdi);
            rise_idx++;
            if (loop_mode) tdo_reg = vji_tdi;
            else if (rise_idx < DR_W) tdo_reg = rnd_word[rise_idx];
        end
    end

    function automatic logic [DR_W-1:0] rnd_dr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DR_W-1:0];
    endfunction

    task automatic start_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr);
        int n = 0;
        @(negedge clk);
        cmd_ir = ir;
        cmd_dr = dr;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        while (!rsp_valid && n < 2 * LAT) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = rsp_valid ? (cyc - accept_cyc) : -1;
    endtask

    task automatic release_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 10000", {vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr});
        end
        checks++;
        if ({vji_tck, vji_tdi, vji_ir_in} !== '0) begin
            errors++;
            $display("FAIL reset_tck_tdi_ir got %b exp 0", {vji_tck, vji_tdi, vji_ir_in});
        end
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake got ready=%b valid=%b exp 1/0", cmd_ready, rsp_valid);
        end
        checks++;
        if (rsp_dr !== '0 || rsp_ir_out !== '0) begin
            errors++;
            $display("FAIL reset_rsp got dr=%h ir=%b exp 0", rsp_dr, rsp_ir_out);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_loopback();
        int lat;
        logic [DR_W-1:0] dr, exp_w, tdi_w;
        for (int it = 0; it < 3; it++) begin
            dr = (it == 0) ? 38'h2A_5A5A_A5A5 : rnd_dr();
            loop_mode = 1'b1;
            first_bit = 1'($urandom_range(0, 1));
            exp_w = {dr[DR_W-2:0], first_bit};
            start_cmd(2'($urandom_range(0, 3)), dr);
            wait_rsp(lat);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL loopback_latency it=%0d got %0d exp %0d", it, lat, LAT);
            end
            checks++;
            if (rsp_dr !== exp_w) begin
                errors++;
                $display("FAIL loopback_data it=%0d got %h exp %h", it, rsp_dr, exp_w);
            end
            tdi_w = '0;
            for (int i = 0; i < tdi_seen.size() && i < DR_W; i++) tdi_w[i] = tdi_seen[i];
            checks++;
            if (tdi_seen.size() != DR_W || tdi_w !== dr) begin
                errors++;
                $display("FAIL loopback_tdi it=%0d got %h (%0d bits) exp %h", it, tdi_w, tdi_seen.size(), dr);
            end
            release_rsp();
        end
    endtask

    task automatic test_random_tdo();
        int lat;
        logic [DR_W-1:0] dr;
        for (int it = 0; it < 3; it++) begin
            dr       = (it == 0) ? '1 : (it == 1) ? '0 : rnd_dr();
            rnd_word = (it == 0) ? '0 : (it == 1) ? '1 : rnd_dr();
            loop_mode = 1'b0;
            rsp_ready = 1'b1;
            start_cmd(2'b01, dr);
            rsp_ready = 1'b1;
            wait_rsp(lat);
            checks++;
            if (lat !== LAT || rsp_dr !== rnd_word) begin
                errors++;
                $display("FAIL tdo_capture it=%0d got lat=%0d dr=%h exp lat=%0d dr=%h", it, lat, rsp_dr, LAT, rnd_word);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_cycle_xfer it=%0d got valid=%b ready=%b exp 0/1", it, rsp_valid, cmd_ready);
            end
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_sequence();
        int k = 0, seq_err = 0, tck_err = 0, ir_err = 0;
        int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, p;
        logic [4:0] exp_f;
        loop_mode = 1'b1;
        start_cmd(2'b10, rnd_dr());
        while (!rsp_valid && k < LAT + 20) begin
            p = k / PER;
            exp_f = {p == 0, p == 1, (p >= 2) && (p < DR_W + 2), p == DR_W + 2, 1'b0};
            if ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== exp_f) seq_err++;
            if (vji_tck !== ((k % PER) >= DIV)) tck_err++;
            if (vji_ir_in !== 2'b10 || cmd_ready !== 1'b0) ir_err++;
            if (vji_uir) n_uir++;
            if (vji_cdr) n_cdr++;
            if (vji_sdr) n_sdr++;
            if (vji_udr) n_udr++;
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k != LAT || seq_err != 0) begin
            errors++;
            $display("FAIL seq_flags got len=%0d bad=%0d exp len=%0d bad=0", k, seq_err, LAT);
        end
        checks++;
        if (n_uir != PER || n_cdr != PER || n_sdr != DR_W * PER || n_udr != PER) begin
            errors++;
            $display("FAIL seq_durations got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
                     n_uir, n_cdr, n_sdr, n_udr, PER, PER, DR_W * PER, PER);
        end
        checks++;
        if (tck_err != 0) begin
            errors++;
            $display("FAIL seq_tck got %0d bad cycles exp 0", tck_err);
        end
        checks++;
        if (ir_err != 0) begin
            errors++;
            $display("FAIL seq_ir_in got %0d bad cycles exp 0", ir_err);
        end
        release_rsp();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vji_ir_in !== 2'b10) begin
            errors++;
            $display("FAIL ir_in_hold got %b exp 10", vji_ir_in);
        end
    endtask

    task automatic test_backpressure();
        int lat, bad = 0, r0;
        logic [DR_W-1:0] dr, exp_w;
        dr = rnd_dr();
        loop_mode = 1'b1;
        first_bit = 1'b1;
        exp_w = {dr[DR_W-2:0], 1'b1};
        start_cmd(2'b11, dr);
        wait_rsp(lat);
        r0 = tck_rises;
        cmd_valid = 1'b1;
        cmd_dr = ~dr;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b1 || rsp_dr !== exp_w || cmd_ready !== 1'b0 || vji_tck !== 1'b0 || vji_rti !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0 || tck_rises != r0) begin
            errors++;
            $display("FAIL backpressure_hold got %0d bad cycles, %0d tck rises exp 0/0", bad, tck_rises - r0);
        end
        cmd_valid = 1'b0;
        release_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || vji_rti !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release got valid=%b ready=%b rti=%b exp 0/1/1", rsp_valid, cmd_ready, vji_rti);
        end
    endtask

    task automatic test_ir_capture();
        int lat, n;
        logic [IR_W-1:0] drive, expv;
        for (int it = 0; it < 2; it++) begin
            drive = (it == 0) ? 2'b11 : 2'($urandom_range(0, 3));
`ifdef JTAG_SCAN_IR_CAPTURE_EN
            expv = drive;
`else
            expv = 2'b00;
`endif
            vji_ir_out = drive;
            start_cmd(2'b00, rnd_dr());
            n = 0;
            while (!vji_sdr && n < LAT) begin
                @(posedge clk);
                #1;
                n++;
            end
            vji_ir_out = ~drive;
            wait_rsp(lat);
            checks++;
            if (rsp_ir_out !== expv) begin
                errors++;
                $display("FAIL ir_capture it=%0d got %b exp %b", it, rsp_ir_out, expv);
            end
            release_rsp();
        end
        vji_ir_out = '0;
    endtask

    task automatic test_reset_mid();
        int n = 0, seen = 0, r0;
        loop_mode = 1'b1;
        start_cmd(2'b01, rnd_dr());
        while (!vji_sdr && n < LAT) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (vji_rti !== 1'b1 || vji_sdr !== 1'b0 || vji_tck !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rti=%b sdr=%b tck=%b ready=%b valid=%b exp 1/0/0/1/0",
                     vji_rti, vji_sdr, vji_tck, cmd_ready, rsp_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        r0 = tck_rises;
        for (int i = 0; i < LAT + 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || tck_rises != r0) begin
            errors++;
            $display("FAIL reset_no_partial got %0d rsp cycles, %0d tck rises exp 0/0", seen, tck_rises - r0);
        end
    endtask

    task automatic test_back_to_back();
        logic [DR_W-1:0] c1, c2, r1, r2;
        logic b1, b2;
        int e = 0, acc1 = -1, acc2 = -1, x1 = -1, x2 = -1, rise_a = 0, rise_b = 0;
        bit sdr_seen = 0;
        c1 = rnd_dr();
        c2 = rnd_dr();
        r1 = '0;
        r2 = '0;
        b1 = 1'($urandom_range(0, 1));
        b2 = 1'($urandom_range(0, 1));
        loop_mode = 1'b1;
        first_bit = b1;
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_ir = 2'b01;
        cmd_dr = c1;
        cmd_valid = 1'b1;
        while (x2 < 0 && e < 4 * LAT) begin
            if (cmd_valid && cmd_ready) begin
                if (acc1 < 0) begin
                    acc1 = e;
                    rise_a = tck_rises;
                end else acc2 = e;
            end
            if (rsp_valid && rsp_ready) begin
                if (x1 < 0) begin
                    x1 = e;
                    r1 = rsp_dr;
                end else begin
                    x2 = e;
                    r2 = rsp_dr;
                    rise_b = tck_rises;
                end
            end
            @(posedge clk);
            e++;
            @(negedge clk);
            if (acc1 >= 0 && acc2 < 0) cmd_dr = c2;
            if (acc2 >= 0) cmd_valid = 1'b0;
            if (acc1 >= 0 && !sdr_seen && vji_sdr) begin
                sdr_seen = 1;
                first_bit = b2;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (acc2 < 0 || x1 < 0 || acc2 != x1 + 1 || acc2 - acc1 != LAT + 2) begin
            errors++;
            $display("FAIL b2b_accept got acc1=%0d x1=%0d acc2=%0d exp acc2=x1+1=acc1+%0d", acc1, x1, acc2, LAT + 2);
        end
        checks++;
        if (r1 !== {c1[DR_W-2:0], b1} || r2 !== {c2[DR_W-2:0], b2}) begin
            errors++;
            $display("FAIL b2b_data got %h %h exp %h %h", r1, r2, {c1[DR_W-2:0], b1}, {c2[DR_W-2:0], b2});
        end
        checks++;
        if (rise_b - rise_a != 2 * (DR_W + 3)) begin
            errors++;
            $display("FAIL b2b_tck_rises got %0d exp %0d", rise_b - rise_a, 2 * (DR_W + 3));
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_random_tdo();
        test_sequence();
        test_backpressure();
        test_ir_capture();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
